score_bitmap_writer: RTL
========================

// Module: score_bitmap_writer
// PURPOSE
// Renders the BCD score into a 2-bit-per-pixel score bitmap RAM through that RAM's write port.
// The scoreboard draw logic reads the RAM with a raster-order address counter.
// Layout matches that counter: row-major, address 0 = top-left pixel.
// Glyphs come from a digit font ROM. Writes happen only during vertical blanking, so no frame tears.
// PARAMETERS
// DIGITS   6  number of BCD digits rendered, MS digit leftmost
// GLYPH_W  8  glyph width in pixels (font row = 2*GLYPH_W bits)
// GLYPH_H  12 glyph height in rows
// BLANK_LZ 1  1: leading zero digits render as colour 0 (LS digit always drawn)
// PORTS
// vga_clk    in  1            pixel clock
// rst        in  1            synchronous, active-high reset
// start      in  1            request redraw; sampled only in IDLE
// score_bcd  in  4*DIGITS     score, digit 0 = bits [3:0] (LS)
// vblank     in  1            1 = vertical blanking; FSM advances only while high
// busy       out 1            redraw in progress
// done       out 1            1-cycle pulse after final write
// font_addr  out 8            digit*GLYPH_H + row; ROM has registered output, latency 1
// font_data  in  2*GLYPH_W    glyph row; pixel p at bits [2*GLYPH_W-1-2p -: 2]
// wr_en      out 1            RAM write strobe
// wr_addr    out 10           row*DIGITS*GLYPH_W + digit_pos*GLYPH_W + px
// wr_data    out 2            pixel colour
// BEHAVIOUR
// - Reset: state IDLE; busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, font_addr=0.
// - FSM states and transitions:
//   IDLE: on start=1, latch score_bcd, clear row, digit_pos and px -> FETCH.
//   FETCH: drive font_addr for (row, digit_pos) -> WAIT.
//   WAIT: ROM latency cycle -> WRITE.
//   WRITE: for px = 0..GLYPH_W-1, wr_en=1, wr_addr per formula, one pixel per cycle.
//   After px = GLYPH_W-1: next digit_pos (MS first); after the last digit, next row; then FETCH.
//   After the last pixel of the last row -> DONE.
//   DONE: done=1 for one cycle, busy=0 -> IDLE.
// - busy=1 in FETCH, WAIT and WRITE.
// - Stall (vblank=0): state, counters and font_addr hold; wr_en=0.
//   Held font_addr keeps font_data valid across the stall.
// - Pixel colour: wr_data = selected 2-bit field of font_data.
// - Digits that render as colour 0: wr_data = 0. These are:
//   - nibbles > 9 (invalid BCD);
//   - leading zeros when BLANK_LZ = 1. A digit is leading if it and every more-significant digit are 0.
// - Start-to-first-write latency: 3 cycles with vblank held high (start edge, FETCH, WAIT).
// - Unstalled redraw: busy for exactly (2+GLYPH_W)*GLYPH_H*DIGITS cycles (720 at defaults).
//   done pulses in the cycle after the final write.
// - start while busy is ignored. score_bcd changes after latch do not affect the redraw in progress.
// - Stall at the DONE transition: the done pulse waits for vblank=1.
// - Reset mid-redraw: immediate IDLE, no done pulse, RAM contents left partial.
// - Address arithmetic: unsigned, 10-bit, never exceeds DIGITS*GLYPH_W*GLYPH_H-1 (575).
// STRUCTURE
// - Shared package: GLYPH_W, GLYPH_H, DIGITS, score RAM depth and address width, FSM state encoding.
//   The scoreboard draw block reuses the same constants.
// - One sub-module, glyph_row_serializer: loads a font row plus a blank flag, shifts out 2-bit pixels MSB-first.
// - The top level holds the FSM, counters and address generation.
// TESTING
// - vblank=1, score 000123, BLANK_LZ=1, start pulse -> wr_en first at cycle 3 with wr_addr=0.
//   Digits 0-2 write all 0; 720 busy cycles; done single pulse.
// - Same run -> wr_addr strictly 0..575 in order, each exactly once.
// - Font model where digit 3 row 0 = 16'hC003 -> writes at addr 40 = 3, addr 47 = 3, addrs 41..46 = 0.
// - Score 000000, BLANK_LZ=1 -> only addrs with px in digit_pos 5 (40..47 per row) may be nonzero.
//   Nibble 4'hA -> that digit fully 0.
// - vblank toggles 0 for 50 cycles mid-redraw -> no wr_en while low, font_addr stable, resumes at next address.
//   Total writes 576.
// - start during busy -> ignored. rst at cycle 200 -> busy=0 next cycle, no done.
//   Fresh start -> complete redraw.

Source files
------------

// File: rtl/score_bitmap_writer_pkg.sv
// Shared constants, state encoding and helpers for the score bitmap.
// The scoreboard draw block reuses the same geometry constants.
package score_bitmap_writer_pkg;

  localparam int unsigned DIGITS    = 6;
  localparam int unsigned GLYPH_W   = 8;
  localparam int unsigned GLYPH_H   = 12;
  localparam int unsigned SCORE_W   = 4 * DIGITS;
  localparam int unsigned FONT_W    = 2 * GLYPH_W;
  localparam int unsigned FONT_AW   = 8;
  localparam int unsigned ROW_PITCH = DIGITS * GLYPH_W;
  localparam int unsigned RAM_DEPTH = DIGITS * GLYPH_W * GLYPH_H;
  localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH);
  localparam int unsigned PX_W      = $clog2(GLYPH_W);
  localparam int unsigned DPOS_W    = $clog2(DIGITS);
  localparam int unsigned ROW_W     = $clog2(GLYPH_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic [3:0] nibble(input logic [SCORE_W-1:0] s, input int unsigned i);
    return s[4*i +: 4];
  endfunction

  // Digit i (0 = LS) renders blank if invalid BCD or a leading zero.
  function automatic logic digit_blank(input logic [SCORE_W-1:0] s, input int unsigned i,
                                       input logic blank_lz);
    logic lead;
    lead = blank_lz && (i != 0);
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (k >= i && nibble(s, k) != 4'd0) lead = 1'b0;
    end
    return (nibble(s, i) > 4'd9) || lead;
  endfunction

  function automatic logic [FONT_AW-1:0] font_index(input logic [3:0] nib,
                                                     input logic [ROW_W-1:0] r);
    return FONT_AW'(nib) * FONT_AW'(GLYPH_H) + FONT_AW'(r);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] r,
                                                 input logic [DPOS_W-1:0] d,
                                                 input logic [PX_W-1:0] p);
    return ADDR_W'(r) * ADDR_W'(ROW_PITCH) + ADDR_W'(d) * ADDR_W'(GLYPH_W) + ADDR_W'(p);
  endfunction

endpackage

// File: rtl/score_bitmap_writer_if.sv
// Control, font ROM and score RAM write-port signals of the score bitmap writer.
interface score_bitmap_writer_if;
  import score_bitmap_writer_pkg::*;

  logic               start;
  logic [SCORE_W-1:0] score_bcd;
  logic               vblank;
  logic               busy;
  logic               done;
  logic [FONT_AW-1:0] font_addr;
  logic [FONT_W-1:0]  font_data;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [1:0]         wr_data;

  modport master (
    output start, score_bcd, vblank, font_data,
    input  busy, done, font_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, score_bcd, vblank, font_data,
    output busy, done, font_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/score_bitmap_writer_glyph_row_serializer.sv
// Holds one glyph row (or zeros when blanked) and shifts out 2-bit pixels MSB-first.
module glyph_row_serializer #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           shift,
  input  logic [2*W-1:0] row_bits,
  input  logic           blank,
  output logic [1:0]     pixel
);

  logic [2*W-1:0] shreg;

  // Blanking is folded in at load so the pixel output comes straight from the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= blank ? '0 : row_bits;
    end else if (shift) begin
      shreg <= {shreg[2*W-3:0], 2'b00};
    end
  end

  assign pixel = shreg[2*W-1 -: 2];

endmodule

// File: rtl/score_bitmap_writer.sv
// Renders the latched BCD score into the 2-bpp score bitmap RAM during vertical blanking.
// Row-major layout, address 0 = top-left pixel, MS digit leftmost.
module score_bitmap_writer
  import score_bitmap_writer_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input logic               vga_clk,
  input logic               rst,
  score_bitmap_writer_if.slave bus
);

  state_t             state;
  logic [SCORE_W-1:0] score;
  logic [PX_W-1:0]    px;
  logic [DPOS_W-1:0]  dpos;
  logic [ROW_W-1:0]   row;
  logic [FONT_AW-1:0] font_addr;
  logic [ADDR_W-1:0]  wr_addr;
  logic               busy;
  logic               done;

  logic               last_px;
  logic               last_dpos;
  logic               last_row;
  logic [DPOS_W-1:0]  dpos_nxt;
  logic [ROW_W-1:0]   row_nxt;
  logic               ser_load;
  logic               ser_shift;
  logic               ser_blank;
  logic [1:0]         pixel;

  // Counter wrap decisions and serializer controls.
  always_comb begin
    last_px   = (px == PX_W'(GLYPH_W - 1));
    last_dpos = (dpos == DPOS_W'(DIGITS - 1));
    last_row  = (row == ROW_W'(GLYPH_H - 1));
    dpos_nxt  = last_dpos ? '0 : dpos + DPOS_W'(1);
    row_nxt   = last_dpos ? row + ROW_W'(1) : row;
    ser_load  = (state == S_WAIT) && bus.vblank;
    ser_shift = (state == S_WRITE) && bus.vblank;
    ser_blank = digit_blank(score, DIGITS - 1 - 32'(dpos), BLANK_LZ);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      score     <= '0;
      px        <= '0;
      dpos      <= '0;
      row       <= '0;
      font_addr <= '0;
      wr_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            score     <= bus.score_bcd;
            px        <= '0;
            dpos      <= '0;
            row       <= '0;
            font_addr <= font_index(nibble(bus.score_bcd, DIGITS - 1), '0);
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.vblank) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.vblank) begin
            wr_addr <= pix_addr(row, dpos, '0);
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.vblank) begin
            if (!last_px) begin
              px      <= px + PX_W'(1);
              wr_addr <= wr_addr + ADDR_W'(1);
            end else begin
              px   <= '0;
              dpos <= dpos_nxt;
              row  <= row_nxt;
              if (last_dpos && last_row) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                font_addr <= font_index(nibble(score, DIGITS - 1 - 32'(dpos_nxt)), row_nxt);
                state     <= S_FETCH;
              end
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  glyph_row_serializer #(.W(GLYPH_W)) u_ser (
    .clk      (vga_clk),
    .rst      (rst),
    .load     (ser_load),
    .shift    (ser_shift),
    .row_bits (bus.font_data),
    .blank    (ser_blank),
    .pixel    (pixel)
  );

  // The strobe is qualified by vblank in the same cycle so no write ever lands outside blanking.
  assign bus.wr_en     = (state == S_WRITE) && bus.vblank;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = pixel;
  assign bus.font_addr = font_addr;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule
